// File: rtl/clk_en_timebase_if.sv
// Run-control, configuration and strobe bundle of the clock-enable timebase.
// The slave side is the timebase; the master side is the system controller.
interface clk_en_timebase_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned CNT_W  = 64
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                    cfg_we;
    logic [CH_W-1:0]         cfg_ch;
    logic [DIV_W-1:0]        cfg_div;
    logic                    cfg_err;
    logic [NUM_CH-1:0]       sus;
    logic                    halt_req;
    logic                    run_req;
    logic                    step_req;
    logic [15:0]             step_cnt;
    logic [NUM_CH-1:0]       clk_en;
    logic [NUM_CH-1:0]       clk_en_g;
    logic [NUM_CH*CNT_W-1:0] cyc;
    logic                    halted;
    logic                    step_done;

    modport master (
        output cfg_we, cfg_ch, cfg_div, sus, halt_req, run_req, step_req, step_cnt,
        input  cfg_err, clk_en, clk_en_g, cyc, halted, step_done
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_div, sus, halt_req, run_req, step_req, step_cnt,
        output cfg_err, clk_en, clk_en_g, cyc, halted, step_done
    );
endinterface

// File: rtl/clk_en_timebase.sv
// Multi-channel clock-enable generator: programmable per-channel divisors, strobe
// counters and a shared halt/run/step controller that freezes all phases together.
module clk_en_timebase #(
    parameter int unsigned             NUM_CH    = 2,
    parameter int unsigned             DIV_W     = 8,
    parameter int unsigned             CNT_W     = 64,
    parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT  = {8'd12, 8'd4},
    parameter int unsigned             STEP_CH   = 1,
    parameter bit                      START_RUN = 1'b1
) (
    input  logic               clock,
    input  logic               reset_n,
    clk_en_timebase_if.slave   bus
);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned REM_W = 16;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    state_e             state_q;
    logic [REM_W-1:0]   rem_q;
    logic               step_done_q;
    logic               cfg_err_q;

    logic [DIV_W-1:0]   ph_q     [NUM_CH];
    logic [DIV_W-1:0]   ph_d     [NUM_CH];
    logic [DIV_W-1:0]   div_q    [NUM_CH];
    logic [DIV_W-1:0]   div_d    [NUM_CH];
    logic [DIV_W-1:0]   pend_q   [NUM_CH];
    logic [DIV_W-1:0]   pend_d   [NUM_CH];
    logic [NUM_CH-1:0]  pend_v_q;
    logic [NUM_CH-1:0]  pend_v_d;
    logic [CNT_W-1:0]   cyc_q    [NUM_CH];
    logic [CNT_W-1:0]   cyc_d    [NUM_CH];

    logic               adv_c;
    logic [NUM_CH-1:0]  wrap_c;
    logic [NUM_CH-1:0]  en_c;
    logic               cfg_ok_c;

    // Strobes are combinational from registers and masked while reset is held.
    assign adv_c    = reset_n && (state_q != ST_HALT);
    assign cfg_ok_c = bus.cfg_we && (bus.cfg_div != '0) && (int'(bus.cfg_ch) < int'(NUM_CH));

    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            wrap_c[i] = (ph_q[i] == (div_q[i] - DIV_W'(1)));
            en_c[i]   = adv_c & wrap_c[i];
        end
    end

    // A staged divisor is only committed on its channel's strobe so no period is cut short.
    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            ph_d[i]     = ph_q[i];
            div_d[i]    = div_q[i];
            pend_d[i]   = pend_q[i];
            pend_v_d[i] = pend_v_q[i];
            cyc_d[i]    = cyc_q[i];
            if (adv_c) begin
                ph_d[i] = wrap_c[i] ? '0 : ph_q[i] + DIV_W'(1);
            end
            if (en_c[i]) begin
                cyc_d[i] = cyc_q[i] + CNT_W'(1);
                if (pend_v_q[i]) begin
                    div_d[i]    = pend_q[i];
                    pend_v_d[i] = 1'b0;
                end
            end
            if (cfg_ok_c && (int'(bus.cfg_ch) == i)) begin
                pend_d[i]   = bus.cfg_div;
                pend_v_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                ph_q[i]   <= '0;
                div_q[i]  <= DIV_INIT[i*DIV_W +: DIV_W];
                pend_q[i] <= '0;
                cyc_q[i]  <= '0;
            end
            pend_v_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            ph_q      <= ph_d;
            div_q     <= div_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            cyc_q     <= cyc_d;
            cfg_err_q <= bus.cfg_we && !cfg_ok_c;
        end
    end

    // Run control; halt_req outranks run_req, which outranks step completion.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= START_RUN ? ST_RUN : ST_HALT;
            rem_q       <= '0;
            step_done_q <= 1'b0;
        end else begin
            step_done_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (bus.halt_req) state_q <= ST_HALT;
                end
                ST_HALT: begin
                    if (!bus.halt_req) begin
                        if (bus.run_req) begin
                            state_q <= ST_RUN;
                        end else if (bus.step_req && (bus.step_cnt != '0)) begin
                            state_q <= ST_STEP;
                            rem_q   <= bus.step_cnt;
                        end
                    end
                end
                ST_STEP: begin
                    if (bus.halt_req) begin
                        state_q <= ST_HALT;
                    end else if (bus.run_req) begin
                        state_q <= ST_RUN;
                    end else if (en_c[STEP_CH]) begin
                        if (rem_q == REM_W'(1)) begin
                            state_q     <= ST_HALT;
                            step_done_q <= 1'b1;
                        end else begin
                            rem_q <= rem_q - REM_W'(1);
                        end
                    end
                end
                default: state_q <= ST_HALT;
            endcase
        end
    end

    assign bus.clk_en    = en_c;
    assign bus.clk_en_g  = en_c & ~bus.sus;
    assign bus.halted    = (state_q == ST_HALT);
    assign bus.step_done = step_done_q;
    assign bus.cfg_err   = cfg_err_q;

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_cyc
        assign bus.cyc[g*CNT_W +: CNT_W] = cyc_q[g];
    end
endmodule

// File: tb/tb_clk_en_timebase.sv
// Scoreboarded bench: stimulus pushes per-cycle expectations from a strobe-schedule
// model; a negedge monitor pops and compares against the timebase outputs.
module tb_clk_en_timebase;
    localparam int STEP_CH = 1;
    localparam int S_RUN = 0, S_HALT = 1, S_STEP = 2;

    typedef struct {
        bit          chk;
        logic [1:0]  en;
        logic [1:0]  en_g;
        logic [127:0] cyc;
        logic        halted;
        logic        sd;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    clk_en_timebase_if #(.NUM_CH(2), .DIV_W(8), .CNT_W(64)) bus ();

    clk_en_timebase #(
        .NUM_CH(2), .DIV_W(8), .CNT_W(64), .DIV_INIT({8'd12, 8'd4}),
        .STEP_CH(1), .START_RUN(1'b1)
    ) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    exp_t expq[$];

    // Stimulus variables applied each cycle.
    bit         r_rst_n;
    bit         r_we;
    bit [0:0]   r_ch;
    bit [7:0]   r_div;
    bit [1:0]   r_sus;
    bit         r_halt, r_run, r_step;
    bit [15:0]  r_cnt;

    // Reference model: strobe schedule in units of advancing cycles.
    int              st;
    int unsigned     rem;
    longint unsigned advn;
    longint unsigned nxt [2];
    int              dv  [2];
    int              pd  [2];
    bit              pv  [2];
    logic [63:0]     cy  [2];
    bit              err_e, sd_e;

    // Strobe observation window for the single-step check.
    bit cnt_on = 1'b0;
    int n_ch1 = 0;
    int n_sd  = 0;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, want);
        end
    endfunction

    function automatic void model_reset();
        st   = S_RUN;
        rem  = 0;
        advn = 0;
        dv[0] = 4;  dv[1] = 12;
        for (int i = 0; i < 2; i++) begin
            nxt[i] = longint'(dv[i]);
            pv[i]  = 1'b0;
            pd[i]  = 0;
            cy[i]  = '0;
        end
        err_e = 1'b0;
        sd_e  = 1'b0;
    endfunction

    task automatic tick();
        exp_t e;
        bit [1:0] fire;
        @(posedge clk);
        #1;
        rst_n        = r_rst_n;
        bus.cfg_we   = r_we;
        bus.cfg_ch   = r_ch;
        bus.cfg_div  = r_div;
        bus.sus      = r_sus;
        bus.halt_req = r_halt;
        bus.run_req  = r_run;
        bus.step_req = r_step;
        bus.step_cnt = r_cnt;
        for (int i = 0; i < 2; i++)
            fire[i] = r_rst_n && (st != S_HALT) && ((advn + 1) == nxt[i]);
        e.chk    = r_rst_n;
        e.en     = fire;
        e.en_g   = fire & ~r_sus;
        e.cyc    = {cy[1], cy[0]};
        e.halted = (st == S_HALT);
        e.sd     = sd_e;
        e.err    = err_e;
        expq.push_back(e);
        if (!r_rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (fire[i]) begin
                    cy[i] = cy[i] + 64'd1;
                    if (pv[i]) begin
                        dv[i] = pd[i];
                        pv[i] = 1'b0;
                    end
                    nxt[i] = nxt[i] + longint'(dv[i]);
                end
            end
            if (st != S_HALT) advn++;
            err_e = r_we && (r_div == 8'd0);
            if (r_we && !err_e) begin
                pd[r_ch] = int'(r_div);
                pv[r_ch] = 1'b1;
            end
            sd_e = 1'b0;
            case (st)
                S_RUN:  if (r_halt) st = S_HALT;
                S_HALT: if (!r_halt) begin
                    if (r_run) st = S_RUN;
                    else if (r_step && r_cnt != 0) begin
                        st  = S_STEP;
                        rem = int'(r_cnt);
                    end
                end
                default: begin
                    if (r_halt) st = S_HALT;
                    else if (r_run) st = S_RUN;
                    else if (fire[STEP_CH]) begin
                        if (rem == 1) begin
                            st   = S_HALT;
                            sd_e = 1'b1;
                        end else begin
                            rem--;
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic idle();
        r_we = 0; r_halt = 0; r_run = 0; r_step = 0; r_cnt = 0;
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pulse_cfg(bit [0:0] ch, bit [7:0] d);
        r_we = 1; r_ch = ch; r_div = d;
        tick();
        r_we = 0;
    endtask

    // Monitor: one expectation per cycle, compared away from the active edge.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("clk_en", 128'(bus.clk_en), 128'(e.en));
            chk("clk_en_g", 128'(bus.clk_en_g), 128'(e.en_g));
            if (e.chk) begin
                chk("cyc", bus.cyc, e.cyc);
                chk("halted", 128'(bus.halted), 128'(e.halted));
                chk("step_done", 128'(bus.step_done), 128'(e.sd));
                chk("cfg_err", 128'(bus.cfg_err), 128'(e.err));
            end
            if (cnt_on) begin
                n_ch1 += int'(bus.clk_en[1]);
                n_sd  += int'(bus.step_done);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.cfg_we = 0; bus.cfg_ch = 0; bus.cfg_div = 0; bus.sus = 0;
        bus.halt_req = 0; bus.run_req = 0; bus.step_req = 0; bus.step_cnt = 0;
        model_reset();
        idle();
        r_sus = 0; r_ch = 0; r_div = 0;

        // Reset then 48 free-running cycles.
        r_rst_n = 0;
        run(3);
        r_rst_n = 1;
        run(48);
        tick();
        chk("t1_cyc_after_48", bus.cyc, {64'd4, 64'd12});
        chk("t1_running", 128'(bus.halted), 128'(0));

        // Divisor change mid-period on ch0.
        pulse_cfg(1'b0, 8'd6);
        run(30);

        // Restore ch0, halt for a long gap, resume.
        pulse_cfg(1'b0, 8'd4);
        run(20);
        r_halt = 1; tick(); r_halt = 0;
        run(100);
        r_run = 1; tick(); r_run = 0;
        run(40);

        // Single step of three ch1 strobes from HALT.
        r_halt = 1; tick(); r_halt = 0;
        run(5);
        cnt_on = 1'b1;
        r_step = 1; r_cnt = 16'd3; tick(); r_step = 0; r_cnt = 0;
        run(60);
        tick();
        cnt_on = 1'b0;
        chk("step_ch1_strobes", 128'(n_ch1), 128'(3));
        chk("step_done_count", 128'(n_sd), 128'(1));
        chk("halted_after_step", 128'(bus.halted), 128'(1));

        // Suspend ch1 for 36 cycles while running.
        r_run = 1; tick(); r_run = 0;
        r_sus = 2'b10;
        run(36);
        r_sus = 2'b00;
        run(10);

        // Rejected writes, then reset in the middle of a step.
        pulse_cfg(1'b0, 8'd0);
        pulse_cfg(1'b1, 8'd0);
        run(30);
        r_halt = 1; tick(); r_halt = 0;
        run(3);
        r_step = 1; r_cnt = 16'd5; tick(); r_step = 0; r_cnt = 0;
        run(20);
        r_rst_n = 0; run(2); r_rst_n = 1;
        run(20);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            r_we    = ($urandom_range(0, 7) == 0);
            r_ch    = 1'($urandom_range(0, 1));
            r_div   = 8'($urandom_range(0, 5));
            r_sus   = 2'($urandom_range(0, 3));
            r_halt  = ($urandom_range(0, 39) == 0);
            r_run   = ($urandom_range(0, 39) == 0);
            r_step  = ($urandom_range(0, 19) == 0);
            r_cnt   = 16'($urandom_range(0, 3));
            r_rst_n = !($urandom_range(0, 499) == 0);
            tick();
        end
        idle();
        r_rst_n = 1;
        run(3);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 128'(expq.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
